// File: rtl/edge_counter.sv
`default_nettype none
// ============================================================================
// Module   : edge_counter
// Brief    : NBITS-wide load/up/down counter with wrap, saturate and one-shot
//            modes. It updates on a compile-time selected clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module edge_counter #(
    parameter int               NBITS       = 8,
    parameter bit               NEGEDGE     = 1'b1,
    parameter logic [NBITS-1:0] RESET_VALUE = '0
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             EN,
    input  logic             LOAD,
    input  logic [NBITS-1:0] LOAD_VALUE,
    input  logic             DIR,
    input  logic [1:0]       MODE,
    input  logic [NBITS-1:0] LIMIT,
    output logic [NBITS-1:0] XOUT,
    output logic             TC,
    output logic             DONE
);

    localparam logic [1:0] C_MODE_WRAP    = 2'd0;
    localparam logic [1:0] C_MODE_SAT     = 2'd1;
    localparam logic [1:0] C_MODE_ONESHOT = 2'd2;
    localparam logic [1:0] C_MODE_HOLD    = 2'd3;

    logic [NBITS-1:0] r_count;
    logic             r_tc;
    logic             r_done;

    logic [NBITS-1:0] w_count_nxt;
    logic [NBITS-1:0] w_term;
    logic [NBITS-1:0] w_step;
    logic             w_at_term;
    logic             w_tc_nxt;
    logic             w_done_nxt;

    always_comb begin
        w_term      = DIR ? '0 : LIMIT;
        w_at_term   = DIR ? (r_count == '0) : (r_count >= LIMIT);
        w_step      = DIR ? (r_count - NBITS'(1)) : (r_count + NBITS'(1));
        w_count_nxt = r_count;
        w_done_nxt  = r_done;
        w_tc_nxt    = 1'b0;

        if (LOAD) begin
            w_count_nxt = LOAD_VALUE;
            w_done_nxt  = 1'b0;
        end else if (EN) begin
            case (MODE)
                C_MODE_WRAP: begin
                    if (w_at_term) w_count_nxt = DIR ? LIMIT : '0;
                    else           w_count_nxt = w_step;
                end
                C_MODE_SAT: begin
                    // Up-count clamps to LIMIT even if the count overshot it
                    if (w_at_term) w_count_nxt = DIR ? '0 : LIMIT;
                    else           w_count_nxt = w_step;
                end
                C_MODE_ONESHOT: begin
                    if (!r_done) begin
                        if (w_at_term) begin
                            w_done_nxt = 1'b1;
                        end else begin
                            w_count_nxt = w_step;
                            if (w_step == w_term) w_done_nxt = 1'b1;
                        end
                    end
                end
                default: w_count_nxt = r_count;
            endcase
            // A step that does not move the count never raises TC
            w_tc_nxt = (MODE != C_MODE_HOLD) && (w_count_nxt == w_term)
                       && (w_count_nxt != r_count);
        end
    end

    if (NEGEDGE) begin : g_negedge
        always_ff @(negedge CLK or negedge RESET_N) begin
            if (!RESET_N) begin
                r_count <= RESET_VALUE;
                r_tc    <= 1'b0;
                r_done  <= 1'b0;
            end else begin
                r_count <= w_count_nxt;
                r_tc    <= w_tc_nxt;
                r_done  <= w_done_nxt;
            end
        end
    end else begin : g_posedge
        always_ff @(posedge CLK or negedge RESET_N) begin
            if (!RESET_N) begin
                r_count <= RESET_VALUE;
                r_tc    <= 1'b0;
                r_done  <= 1'b0;
            end else begin
                r_count <= w_count_nxt;
                r_tc    <= w_tc_nxt;
                r_done  <= w_done_nxt;
            end
        end
    end

    assign XOUT = r_count;
    assign TC   = r_tc;
    assign DONE = r_done;

endmodule
`default_nettype wire

// File: tb/tb_edge_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_edge_counter
// Brief    : Scoreboard bench for edge_counter, covering a falling-edge
//            instance (RESET_VALUE=5) and a rising-edge instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_edge_counter;

    logic       clk = 1'b0;
    logic       rst_n, en, load, dir;
    logic [7:0] load_value, limit;
    logic [1:0] mode;
    logic [7:0] xout;
    logic       tc, done;

    logic       p_rst_n, p_en;
    logic [7:0] p_limit;
    logic [7:0] p_xout;
    logic       p_tc, p_done;
    logic       p_zero   = 1'b0;
    logic [7:0] p_zero8  = 8'd0;
    logic [1:0] p_mode   = 2'd0;

    typedef struct packed {
        logic [7:0] x;
        logic       tc;
        logic       done;
    } exp_t;

    typedef struct packed {
        logic       ld;
        logic [7:0] lv;
        logic [7:0] lim;
        logic [1:0] md;
        logic       dr;
        logic [7:0] x;
        logic       t;
        logic       d;
    } vec_t;

    exp_t sb[$];
    exp_t e;
    int   errors = 0;
    int   checks = 0;

    edge_counter #(.NBITS(8), .NEGEDGE(1'b1), .RESET_VALUE(8'd5)) u_dut_neg (
        .CLK(clk), .RESET_N(rst_n), .EN(en), .LOAD(load), .LOAD_VALUE(load_value),
        .DIR(dir), .MODE(mode), .LIMIT(limit), .XOUT(xout), .TC(tc), .DONE(done)
    );

    edge_counter #(.NBITS(8), .NEGEDGE(1'b0), .RESET_VALUE(8'd0)) u_dut_pos (
        .CLK(clk), .RESET_N(p_rst_n), .EN(p_en), .LOAD(p_zero), .LOAD_VALUE(p_zero8),
        .DIR(p_zero), .MODE(p_mode), .LIMIT(p_limit), .XOUT(p_xout), .TC(p_tc),
        .DONE(p_done)
    );

    always #5 clk = ~clk;

    initial begin
        #90000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_vec(input vec_t v);
        load       = v.ld;
        load_value = v.lv;
        limit      = v.lim;
        mode       = v.md;
        dir        = v.dr;
        sb.push_back(exp_t'{v.x, v.t, v.d});
    endtask

    task automatic test_reset();
        rst_n = 1'b1; p_rst_n = 1'b1; en = 1'b0; load = 1'b0; load_value = 8'd0;
        dir = 1'b0; mode = 2'd0; limit = 8'd200; p_en = 1'b0; p_limit = 8'd3;
        #2;
        rst_n = 1'b0; p_rst_n = 1'b0;
        #1;
        checks++;
        if (xout !== 8'd5 || tc !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: xout=%0d tc=%b done=%b, expected 5 0 0", xout, tc, done);
        end
        checks++;
        if (p_xout !== 8'd0 || p_tc !== 1'b0 || p_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_async_pos: xout=%0d tc=%b done=%b, expected 0 0 0", p_xout, p_tc, p_done);
        end
        @(posedge clk);
        rst_n = 1'b1;
        en    = 1'b1;
        sb.push_back(exp_t'{8'd6, 1'b0, 1'b0});
        #1;
        checks++;
        if (xout !== 8'd5) begin
            errors++;
            $display("FAIL reset_release_hold: xout=%0d, expected 5", xout);
        end
        @(negedge clk);
        p_rst_n = 1'b1;
        #1;
        e = sb.pop_front();
        checks++;
        if (xout !== e.x || tc !== e.tc || done !== e.done) begin
            errors++;
            $display("FAIL reset_first_edge: xout=%0d tc=%b done=%b, expected %0d %b %b",
                     xout, tc, done, e.x, e.tc, e.done);
        end
    endtask

    task automatic test_edge_select_neg();
        vec_t v[6] = '{
            '{1'b1, 8'd0, 8'd3, 2'd0, 1'b0, 8'd0, 1'b0, 1'b0},
            '{1'b0, 8'd0, 8'd3, 2'd0, 1'b0, 8'd1, 1'b0, 1'b0},
            '{1'b0, 8'd0, 8'd3, 2'd0, 1'b0, 8'd2, 1'b0, 1'b0},
            '{1'b0, 8'd0, 8'd3, 2'd0, 1'b0, 8'd3, 1'b1, 1'b0},
            '{1'b0, 8'd0, 8'd3, 2'd0, 1'b0, 8'd0, 1'b0, 1'b0},
            '{1'b0, 8'd0, 8'd3, 2'd0, 1'b0, 8'd1, 1'b0, 1'b0}};
        logic [7:0] prev = 8'd6;
        en = 1'b1;
        foreach (v[i]) begin
            apply_vec(v[i]);
            @(posedge clk); #1;
            checks++;
            if (xout !== prev) begin
                errors++;
                $display("FAIL edge_neg_inactive step %0d: xout=%0d, expected %0d", i, xout, prev);
            end
            @(negedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (xout !== e.x || tc !== e.tc || done !== e.done) begin
                errors++;
                $display("FAIL edge_neg step %0d: xout=%0d tc=%b done=%b, expected %0d %b %b",
                         i, xout, tc, done, e.x, e.tc, e.done);
            end
            prev = e.x;
        end
    endtask

    task automatic test_edge_select_pos();
        logic [7:0] xs [5] = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd1};
        logic       ts [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        p_en = 1'b1;
        foreach (xs[i]) begin
            sb.push_back(exp_t'{xs[i], ts[i], 1'b0});
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (p_xout !== e.x || p_tc !== e.tc || p_done !== e.done) begin
                errors++;
                $display("FAIL edge_pos step %0d: xout=%0d tc=%b done=%b, expected %0d %b %b",
                         i, p_xout, p_tc, p_done, e.x, e.tc, e.done);
            end
            @(negedge clk); #1;
            checks++;
            if (p_xout !== e.x || p_tc !== e.tc) begin
                errors++;
                $display("FAIL edge_pos_inactive step %0d: xout=%0d tc=%b, expected %0d %b",
                         i, p_xout, p_tc, e.x, e.tc);
            end
        end
        p_en = 1'b0;
    endtask

    task automatic test_saturate_down();
        vec_t v[5] = '{
            '{1'b1, 8'd2, 8'd9, 2'd1, 1'b1, 8'd2, 1'b0, 1'b0},
            '{1'b0, 8'd2, 8'd9, 2'd1, 1'b1, 8'd1, 1'b0, 1'b0},
            '{1'b0, 8'd2, 8'd9, 2'd1, 1'b1, 8'd0, 1'b1, 1'b0},
            '{1'b0, 8'd2, 8'd9, 2'd1, 1'b1, 8'd0, 1'b0, 1'b0},
            '{1'b0, 8'd2, 8'd9, 2'd1, 1'b1, 8'd0, 1'b0, 1'b0}};
        en = 1'b1;
        foreach (v[i]) begin
            apply_vec(v[i]);
            @(negedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (xout !== e.x || tc !== e.tc || done !== e.done) begin
                errors++;
                $display("FAIL saturate_down step %0d: xout=%0d tc=%b done=%b, expected %0d %b %b",
                         i, xout, tc, done, e.x, e.tc, e.done);
            end
        end
    endtask

    task automatic test_one_shot();
        vec_t v[9] = '{
            '{1'b1, 8'd0, 8'd4, 2'd2, 1'b0, 8'd0, 1'b0, 1'b0},
            '{1'b0, 8'd0, 8'd4, 2'd2, 1'b0, 8'd1, 1'b0, 1'b0},
            '{1'b0, 8'd0, 8'd4, 2'd2, 1'b0, 8'd2, 1'b0, 1'b0},
            '{1'b0, 8'd0, 8'd4, 2'd2, 1'b0, 8'd3, 1'b0, 1'b0},
            '{1'b0, 8'd0, 8'd4, 2'd2, 1'b0, 8'd4, 1'b1, 1'b1},
            '{1'b0, 8'd0, 8'd4, 2'd2, 1'b0, 8'd4, 1'b0, 1'b1},
            '{1'b0, 8'd0, 8'd4, 2'd2, 1'b0, 8'd4, 1'b0, 1'b1},
            '{1'b1, 8'd1, 8'd4, 2'd2, 1'b0, 8'd1, 1'b0, 1'b0},
            '{1'b0, 8'd1, 8'd4, 2'd2, 1'b0, 8'd2, 1'b0, 1'b0}};
        en = 1'b1;
        foreach (v[i]) begin
            apply_vec(v[i]);
            @(negedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (xout !== e.x || tc !== e.tc || done !== e.done) begin
                errors++;
                $display("FAIL one_shot step %0d: xout=%0d tc=%b done=%b, expected %0d %b %b",
                         i, xout, tc, done, e.x, e.tc, e.done);
            end
        end
    endtask

    task automatic test_limit_lowered();
        vec_t v[5] = '{
            '{1'b1, 8'd10, 8'd20, 2'd0, 1'b0, 8'd10, 1'b0, 1'b0},
            '{1'b0, 8'd10, 8'd6,  2'd0, 1'b0, 8'd0,  1'b0, 1'b0},
            '{1'b1, 8'd10, 8'd20, 2'd1, 1'b0, 8'd10, 1'b0, 1'b0},
            '{1'b0, 8'd10, 8'd6,  2'd1, 1'b0, 8'd6,  1'b1, 1'b0},
            '{1'b0, 8'd10, 8'd6,  2'd1, 1'b0, 8'd6,  1'b0, 1'b0}};
        en = 1'b1;
        foreach (v[i]) begin
            apply_vec(v[i]);
            @(negedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (xout !== e.x || tc !== e.tc || done !== e.done) begin
                errors++;
                $display("FAIL limit_lowered step %0d: xout=%0d tc=%b done=%b, expected %0d %b %b",
                         i, xout, tc, done, e.x, e.tc, e.done);
            end
        end
    endtask

    task automatic test_wrap_hold();
        vec_t v[8] = '{
            '{1'b1, 8'd0, 8'd0, 2'd0, 1'b0, 8'd0, 1'b0, 1'b0},
            '{1'b0, 8'd0, 8'd0, 2'd0, 1'b0, 8'd0, 1'b0, 1'b0},
            '{1'b0, 8'd0, 8'd0, 2'd0, 1'b0, 8'd0, 1'b0, 1'b0},
            '{1'b1, 8'd1, 8'd9, 2'd0, 1'b1, 8'd1, 1'b0, 1'b0},
            '{1'b0, 8'd1, 8'd9, 2'd0, 1'b1, 8'd0, 1'b1, 1'b0},
            '{1'b0, 8'd1, 8'd9, 2'd0, 1'b1, 8'd9, 1'b0, 1'b0},
            '{1'b1, 8'd3, 8'd3, 2'd3, 1'b0, 8'd3, 1'b0, 1'b0},
            '{1'b0, 8'd3, 8'd3, 2'd3, 1'b0, 8'd3, 1'b0, 1'b0}};
        en = 1'b1;
        foreach (v[i]) begin
            apply_vec(v[i]);
            @(negedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (xout !== e.x || tc !== e.tc || done !== e.done) begin
                errors++;
                $display("FAIL wrap_hold step %0d: xout=%0d tc=%b done=%b, expected %0d %b %b",
                         i, xout, tc, done, e.x, e.tc, e.done);
            end
        end
    endtask

    task automatic test_conflicts();
        vec_t v[5] = '{
            '{1'b1, 8'd5, 8'd6, 2'd0, 1'b0, 8'd5, 1'b0, 1'b0},
            '{1'b0, 8'd5, 8'd6, 2'd0, 1'b0, 8'd6, 1'b1, 1'b0},
            '{1'b1, 8'd6, 8'd6, 2'd0, 1'b0, 8'd6, 1'b0, 1'b0},
            '{1'b1, 8'd5, 8'd6, 2'd0, 1'b0, 8'd5, 1'b0, 1'b0},
            '{1'b0, 8'd5, 8'd6, 2'd0, 1'b0, 8'd6, 1'b1, 1'b0}};
        en = 1'b1;
        foreach (v[i]) begin
            apply_vec(v[i]);
            @(negedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (xout !== e.x || tc !== e.tc || done !== e.done) begin
                errors++;
                $display("FAIL conflicts step %0d: xout=%0d tc=%b done=%b, expected %0d %b %b",
                         i, xout, tc, done, e.x, e.tc, e.done);
            end
        end
        rst_n = 1'b0;
        en    = 1'b0;
        #1;
        checks++;
        if (tc !== 1'b0 || xout !== 8'd5 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_tc: xout=%0d tc=%b done=%b, expected 5 0 0", xout, tc, done);
        end
        @(posedge clk);
        rst_n = 1'b1;
        sb.push_back(exp_t'{8'd5, 1'b0, 1'b0});
        @(negedge clk); #1;
        e = sb.pop_front();
        checks++;
        if (xout !== e.x || tc !== e.tc || done !== e.done) begin
            errors++;
            $display("FAIL reset_mid_release: xout=%0d tc=%b done=%b, expected %0d %b %b",
                     xout, tc, done, e.x, e.tc, e.done);
        end
    endtask

    initial begin
        test_reset();
        test_edge_select_neg();
        test_edge_select_pos();
        test_saturate_down();
        test_one_shot();
        test_limit_lowered();
        test_wrap_hold();
        test_conflicts();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/edge_counter.md
# edge_counter

Parametrised NBITS-wide counter that updates on a compile-time-selected clock edge (falling by default). It supports load, up/down direction, wrap/saturate/one-shot modes, a programmable limit, a terminal-count pulse and a sticky done flag. It is the generalised replacement for fixed-width, reset-only negative-edge registers. Typical uses are timers, prescalers and event counters in blocks clocked on the opposite edge of their neighbours.

## Interface
- NBITS, 8, counter width; must be ≥ 1.
- NEGEDGE, 1, 1 = state updates on falling edge of CLK, 0 = rising edge.
- RESET_VALUE, 0, value loaded into XOUT by reset, truncated to NBITS.

- CLK  in  1  clock; only the edge selected by NEGEDGE (the "active edge") changes state.
- RESET_N  in  1  one clock; reset is asynchronous and active-low.
- EN  in  1  count enable.
- LOAD  in  1  synchronous load request.
- LOAD_VALUE  in  NBITS  value loaded when LOAD=1.
- DIR  in  1  0 = count up, 1 = count down.
- MODE  in  2  0 = wrap, 1 = saturate, 2 = one-shot, 3 = hold (reserved).
- LIMIT  in  NBITS  upper terminal value; treated as unsigned.
- XOUT  out  NBITS  registered count.
- TC  out  1  registered terminal-count pulse.
- DONE  out  1  registered sticky one-shot completion flag.

## Operation
- Reset (RESET_N=0) overrides everything: XOUT=RESET_VALUE, TC=0, DONE=0.
- Priority at each active edge, with RESET_N=1: LOAD > EN count > hold.
- Terminal value T: LIMIT when DIR=0; 0 when DIR=1. "At terminal" means:
  - up: XOUT ≥ LIMIT;
  - down: XOUT == 0.
- LOAD=1: XOUT=LOAD_VALUE, DONE=0, TC=0. This applies even if LOAD_VALUE equals T.
- EN=1, LOAD=0, not at terminal: XOUT = XOUT+1 (up) or XOUT−1 (down). This is never modulo 2^NBITS.
- EN=1, LOAD=0, at terminal:
  - wrap: up → 0; down → LIMIT.
  - saturate: up → LIMIT (clamps when XOUT > LIMIT); down → holds 0.
  - one-shot: holds XOUT; sets DONE.
  - hold (3): holds XOUT.
- One-shot with DONE=1: EN is ignored and XOUT holds until LOAD or reset.
- TC: next-state value is 1 iff an enabled count step (LOAD=0, MODE≠3) produces XOUT_next == T and XOUT_next ≠ XOUT. Otherwise it is 0.
  - TC is therefore a one-active-edge-period pulse.
  - In saturate mode TC does not repeat while held.
- DONE in one-shot mode is also set on the same edge at which the count step lands on T. DONE and TC rise together.
- LIMIT=0 in wrap mode with DIR=0: XOUT stays 0 and TC never asserts.
- DIR, MODE and LIMIT are sampled at each active edge. Changes take effect at the next active edge, with no pipeline flush.
- Arithmetic is unsigned NBITS. The terminal checks prevent underflow and overflow, so no wrap through 2^NBITS occurs unless LIMIT = 2^NBITS−1.

## Timing
- Latency: inputs sampled at active edge N appear on XOUT/TC/DONE immediately after edge N (one-edge latency).
- The inactive CLK edge never changes any output.
- Reset assertion: outputs take reset values asynchronously, with no CLK edge required.
- Reset deassertion must occur away from the active edge (the bench releases it at the inactive edge). The first update is at the first active edge after release.
- Reset mid-count: TC pulse and DONE clear immediately. Count restarts from RESET_VALUE.
- LOAD and EN both high on the same edge: load wins and no TC is generated.
- All outputs are driven directly from flops, with no combinational input-to-output path.

## Test plan
- Reset: NBITS=8, RESET_VALUE=5, assert RESET_N=0 between edges → XOUT=5, TC=0, DONE=0 before any CLK edge. Release at rising edge; first change at following falling edge.
- Edge select: NEGEDGE=1, EN=1, up, wrap, LIMIT=3 → XOUT changes only on falling edges: 0,1,2,3,0,1. TC high exactly in the period after XOUT becomes 3. Repeat with NEGEDGE=0, where changes occur on rising edges only.
- Saturate down: LOAD 2, DIR=1, MODE=1, EN=1 → 1,0,0,0. TC pulses once when 0 is reached, then stays 0.
- One-shot: LOAD 0, LIMIT=4, MODE=2, EN=1 → 1,2,3,4, then holds 4. DONE=1 and TC pulses at the edge reaching 4, and DONE stays 1 with EN high. LOAD 1 → DONE=0 and counting resumes.
- Limit lowered: counting up, wrap, at XOUT=10 set LIMIT=6 → next edge XOUT=0 with no TC. In saturate mode the same scenario gives XOUT=6 and TC=1.
- Conflicts: LOAD=1 with LOAD_VALUE=LIMIT and EN=1 → XOUT=LIMIT, TC=0. Assert RESET_N=0 while TC=1 → TC=0 immediately.
